// File: rtl/dma_sched_pkg.sv
// Shared state type, default widths and modular counter helper for dma_buf_scheduler.
package dma_sched_pkg;

   localparam int DEF_ADR_W = 28;
   localparam int DEF_CNT_W = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_ISSUE,
      S_GAP,
      S_FLUSH
   } sched_state_e;

   // Callers truncate the result to their counter width to obtain the modular distance a-b.
   function automatic logic [31:0] cnt_diff(input logic [31:0] a, input logic [31:0] b);
      return a - b;
   endfunction

endpackage

// File: rtl/dma_done_min.sv
// Registered minimum of per-channel DONE_CNT progress since the captured base counts.
module dma_done_min
   import dma_sched_pkg::*;
#(
   parameter int NCH   = 3,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 clr_i,
   input  logic                 en_i,
   input  logic [NCH*CNT_W-1:0] done_cnt_i,
   input  logic [NCH*CNT_W-1:0] done_base_i,
   output logic [CNT_W-1:0]     completed_o
);

   logic [CNT_W-1:0] min_d;
   logic [CNT_W-1:0] delta;

   always_comb begin
      min_d = '1;
      delta = '0;
      for (int ch = 0; ch < NCH; ch++) begin
         delta = CNT_W'(cnt_diff(32'(done_cnt_i[ch*CNT_W +: CNT_W]),
                                 32'(done_base_i[ch*CNT_W +: CNT_W])));
         if (delta < min_d) min_d = delta;
      end
   end

   // Cleared on a new run so the stale pre-run delta is never seen as progress.
   always_ff @(posedge CLK) begin
      if (RST || clr_i) completed_o <= '0;
      else if (en_i)    completed_o <= min_d;
   end

endmodule

// File: rtl/dma_buf_scheduler.sv
// Ring-buffer command scheduler for NCH lockstep DMA channels.
// Optional watchdog enabled by defining DMA_SCHED_TIMEOUT_EN.
module dma_buf_scheduler
   import dma_sched_pkg::*;
#(
   parameter int NCH            = 3,
   parameter int ADR_W          = DEF_ADR_W,
   parameter int CNT_W          = DEF_CNT_W,
   parameter int CMD_DEPTH      = 1,
   parameter int TIMEOUT_CYCLES = 2**24
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 RUN,
   input  logic                 STOP,
   input  logic [ADR_W-1:0]     CFG_BASE_ADR,
   input  logic [ADR_W-1:0]     CFG_CH_STRIDE,
   input  logic [ADR_W-1:0]     CFG_BUF_SIZE,
   input  logic [CNT_W-1:0]     CFG_RING_BUFS,
   input  logic [CNT_W-1:0]     CFG_BUF_TOTAL,
   input  logic                 HOST_RELEASE,
   input  logic [NCH*CNT_W-1:0] DMA_DONE_CNT,
   output logic [NCH-1:0]       DMA_START,
   output logic [NCH*ADR_W-1:0] DMA_START_ADR,
   output logic [ADR_W-1:0]     DMA_BUF_SIZE,
   output logic                 BUF_DONE,
   output logic [CNT_W-1:0]     BUF_DONE_IDX,
   output logic                 BUSY,
   output logic                 ALL_DONE,
   output logic                 ERR_RELEASE,
   output logic                 ERR_TIMEOUT
);

   sched_state_e         state_q, state_d;
   logic [ADR_W-1:0]     buf_size_q, buf_size_d, offset_q, offset_d;
   logic [CNT_W-1:0]     ring_q, ring_d, total_q, total_d;
   logic [NCH*ADR_W-1:0] ch_base_q, ch_base_d, adr_q, adr_d;
   logic [NCH*CNT_W-1:0] done_base_q, done_base_d;
   logic [CNT_W-1:0]     issued_q, issued_d, released_q, released_d, idx_q, idx_d;
   logic [CNT_W-1:0]     seen_q, seen_d, owed_q, owed_d, done_idx_q, done_idx_d;
   logic [CNT_W-1:0]     buf_done_idx_q, buf_done_idx_d;
   logic                 stop_pend_q, stop_pend_d, buf_done_q, buf_done_d;
   logic                 all_done_q, all_done_d, err_rel_q, err_rel_d;
   logic [CNT_W-1:0]     completed, occ_cmd, occ_ring, occ_host, owed_sum;
   logic [ADR_W-1:0]     base_acc;
   logic                 run_go, can_issue, timeout_hit;

   dma_done_min #(.NCH(NCH), .CNT_W(CNT_W)) u_done_min (
      .CLK         (CLK),
      .RST         (RST),
      .clr_i       (run_go),
      .en_i        (state_q != S_IDLE),
      .done_cnt_i  (DMA_DONE_CNT),
      .done_base_i (done_base_q),
      .completed_o (completed)
   );

   assign run_go    = RUN && (state_q == S_IDLE);
   assign occ_cmd   = CNT_W'(cnt_diff(32'(issued_q), 32'(completed)));
   assign occ_ring  = CNT_W'(cnt_diff(32'(issued_q), 32'(released_q)));
   assign occ_host  = CNT_W'(cnt_diff(32'(completed), 32'(released_q)));
   assign owed_sum  = owed_q + CNT_W'(cnt_diff(32'(completed), 32'(seen_q)));
   assign can_issue = (occ_cmd < CNT_W'(CMD_DEPTH)) && (occ_ring < ring_q) &&
                      ((total_q == '0) || (issued_q < total_q)) && !stop_pend_q && !STOP;

   always_comb begin
      state_d        = state_q;
      buf_size_d     = buf_size_q;
      offset_d       = offset_q;
      ring_d         = ring_q;
      total_d        = total_q;
      ch_base_d      = ch_base_q;
      adr_d          = adr_q;
      done_base_d    = done_base_q;
      issued_d       = issued_q;
      released_d     = released_q;
      idx_d          = idx_q;
      done_idx_d     = done_idx_q;
      buf_done_idx_d = buf_done_idx_q;
      stop_pend_d    = stop_pend_q;
      all_done_d     = all_done_q;
      err_rel_d      = err_rel_q;
      base_acc       = CFG_BASE_ADR;
      seen_d         = completed;
      owed_d         = owed_sum;
      buf_done_d     = (owed_sum != '0);

      // Completions arriving in bursts are paid out one BUF_DONE per cycle.
      if (buf_done_d) begin
         owed_d         = owed_sum - CNT_W'(1);
         buf_done_idx_d = done_idx_q;
         done_idx_d     = (done_idx_q + CNT_W'(1) == ring_q) ? '0 : done_idx_q + CNT_W'(1);
      end

      if (HOST_RELEASE) begin
         if (occ_host != '0) released_d = released_q + CNT_W'(1);
         else                err_rel_d  = 1'b1;
      end

      if (STOP && state_q != S_IDLE) stop_pend_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (RUN) begin
               state_d     = S_ARM;
               buf_size_d  = CFG_BUF_SIZE;
               ring_d      = CFG_RING_BUFS;
               total_d     = CFG_BUF_TOTAL;
               for (int ch = 0; ch < NCH; ch++) begin
                  ch_base_d[ch*ADR_W +: ADR_W] = base_acc;
                  base_acc = base_acc + CFG_CH_STRIDE;
               end
               done_base_d = DMA_DONE_CNT;
               issued_d    = '0;
               released_d  = '0;
               idx_d       = '0;
               offset_d    = '0;
               seen_d      = '0;
               owed_d      = '0;
               done_idx_d  = '0;
               buf_done_d  = 1'b0;
               all_done_d  = 1'b0;
               err_rel_d   = 1'b0;
               stop_pend_d = 1'b0;
            end
         end
         S_ARM: begin
            if (total_q != '0 && completed == total_q) begin
               all_done_d = 1'b1;
               state_d    = S_IDLE;
            end else if (stop_pend_q || STOP) begin
               state_d = S_FLUSH;
            end else if (can_issue) begin
               state_d = S_ISSUE;
               for (int ch = 0; ch < NCH; ch++)
                  adr_d[ch*ADR_W +: ADR_W] = ch_base_q[ch*ADR_W +: ADR_W] + offset_q;
            end
         end
         S_ISSUE: begin
            issued_d = issued_q + CNT_W'(1);
            state_d  = S_GAP;
         end
         S_GAP: begin
            if (idx_q + CNT_W'(1) == ring_q) begin
               idx_d    = '0;
               offset_d = '0;
            end else begin
               idx_d    = idx_q + CNT_W'(1);
               offset_d = offset_q + buf_size_q;
            end
            state_d = S_ARM;
         end
         S_FLUSH: begin
            if (completed == issued_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (timeout_hit) state_d = S_IDLE;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q        <= S_IDLE;
         buf_size_q     <= '0;
         offset_q       <= '0;
         ring_q         <= '0;
         total_q        <= '0;
         ch_base_q      <= '0;
         adr_q          <= '0;
         done_base_q    <= '0;
         issued_q       <= '0;
         released_q     <= '0;
         idx_q          <= '0;
         seen_q         <= '0;
         owed_q         <= '0;
         done_idx_q     <= '0;
         buf_done_idx_q <= '0;
         stop_pend_q    <= 1'b0;
         buf_done_q     <= 1'b0;
         all_done_q     <= 1'b0;
         err_rel_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         buf_size_q     <= buf_size_d;
         offset_q       <= offset_d;
         ring_q         <= ring_d;
         total_q        <= total_d;
         ch_base_q      <= ch_base_d;
         adr_q          <= adr_d;
         done_base_q    <= done_base_d;
         issued_q       <= issued_d;
         released_q     <= released_d;
         idx_q          <= idx_d;
         seen_q         <= seen_d;
         owed_q         <= owed_d;
         done_idx_q     <= done_idx_d;
         buf_done_idx_q <= buf_done_idx_d;
         stop_pend_q    <= stop_pend_d;
         buf_done_q     <= buf_done_d;
         all_done_q     <= all_done_d;
         err_rel_q      <= err_rel_d;
      end
   end

`ifdef DMA_SCHED_TIMEOUT_EN
   logic [31:0] wd_q, wd_d;
   logic        err_to_q, err_to_d;

   // Watchdog only runs while work is outstanding and progress has stalled.
   always_comb begin
      wd_d     = wd_q + 32'd1;
      err_to_d = err_to_q || timeout_hit;
      if (state_q == S_IDLE || completed != seen_q || issued_q == completed) wd_d = '0;
   end

   always_ff @(posedge CLK) begin
      if (RST || run_go) begin
         wd_q     <= '0;
         err_to_q <= 1'b0;
      end else begin
         wd_q     <= wd_d;
         err_to_q <= err_to_d;
      end
   end

   assign timeout_hit = (state_q != S_IDLE) && (wd_q == 32'(TIMEOUT_CYCLES - 1));
   assign ERR_TIMEOUT = err_to_q;
`else
   assign timeout_hit = 1'b0;
   assign ERR_TIMEOUT = 1'b0;
`endif

   assign DMA_START     = {NCH{state_q == S_ISSUE}};
   assign DMA_START_ADR = adr_q;
   assign DMA_BUF_SIZE  = buf_size_q;
   assign BUF_DONE      = buf_done_q;
   assign BUF_DONE_IDX  = buf_done_idx_q;
   assign BUSY          = (state_q != S_IDLE);
   assign ALL_DONE      = all_done_q;
   assign ERR_RELEASE   = err_rel_q;

endmodule

// File: tb/tb_dma_buf_scheduler.sv
// Self-checking bench for dma_buf_scheduler with channel and host behavioural models.
module tb_dma_buf_scheduler;

   localparam int NCH   = 3;
   localparam int ADR_W = 28;
   localparam int CNT_W = 16;

   typedef struct packed {
      logic [ADR_W-1:0] a2;
      logic [ADR_W-1:0] a1;
      logic [ADR_W-1:0] a0;
   } adr_set_t;

   logic                 CLK = 1'b0;
   logic                 RST = 1'b1;
   logic                 RUN = 1'b0;
   logic                 STOP = 1'b0;
   logic [ADR_W-1:0]     cfgBase = '0, cfgStride = '0, cfgBufSize = '0;
   logic [CNT_W-1:0]     cfgRing = '0, cfgTotal = '0;
   logic                 HOST_RELEASE = 1'b0;
   logic [NCH*CNT_W-1:0] doneCntFlat;
   logic [NCH-1:0]       dmaStart;
   logic [NCH*ADR_W-1:0] dmaStartAdr;
   logic [ADR_W-1:0]     dmaBufSize;
   logic                 bufDone, busy, allDone, errRelease, errTimeout;
   logic [CNT_W-1:0]     bufDoneIdx;

   logic [CNT_W-1:0]     dc [NCH];
   logic [CNT_W-1:0]     preload [NCH];
   int                   lat [NCH];
   int                   timer [NCH];
   int                   startCnt [NCH];
   adr_set_t             startQ [$];
   logic [CNT_W-1:0]     doneQ [$];
   longint               relQ [$];
   longint               cyc = 0;
   bit                   envClear = 1'b1;
   bit                   autoRel = 1'b0;
   int                   relDelay = 20;
   int                   manReq = 0, manSeen = 0;
   int                   nChecks = 0, nPass = 0, nFail = 0;

   assign doneCntFlat = {dc[2], dc[1], dc[0]};

   always #5 CLK = ~CLK;

   dma_buf_scheduler #(.NCH(NCH), .ADR_W(ADR_W), .CNT_W(CNT_W), .CMD_DEPTH(1)) dut (
      .CLK           (CLK),
      .RST           (RST),
      .RUN           (RUN),
      .STOP          (STOP),
      .CFG_BASE_ADR  (cfgBase),
      .CFG_CH_STRIDE (cfgStride),
      .CFG_BUF_SIZE  (cfgBufSize),
      .CFG_RING_BUFS (cfgRing),
      .CFG_BUF_TOTAL (cfgTotal),
      .HOST_RELEASE  (HOST_RELEASE),
      .DMA_DONE_CNT  (doneCntFlat),
      .DMA_START     (dmaStart),
      .DMA_START_ADR (dmaStartAdr),
      .DMA_BUF_SIZE  (dmaBufSize),
      .BUF_DONE      (bufDone),
      .BUF_DONE_IDX  (bufDoneIdx),
      .BUSY          (busy),
      .ALL_DONE      (allDone),
      .ERR_RELEASE   (errRelease),
      .ERR_TIMEOUT   (errTimeout)
   );

   // Environment on the falling edge: channel DONE_CNT models, host release model, and a
   // recorder of every START and BUF_DONE seen on the outputs.
   always @(negedge CLK) begin
      logic     hr;
      adr_set_t s;
      cyc++;
      if (envClear) begin
         for (int c = 0; c < NCH; c++) begin
            dc[c]       = preload[c];
            timer[c]    = 0;
            startCnt[c] = 0;
         end
         startQ.delete();
         doneQ.delete();
         relQ.delete();
         manSeen      = manReq;
         HOST_RELEASE = 1'b0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (dmaStart[c]) begin
               startCnt[c]++;
               timer[c] = lat[c];
            end else if (timer[c] > 0) begin
               timer[c]--;
               if (timer[c] == 0) dc[c] = dc[c] + 1'b1;
            end
         end
         if (dmaStart[0]) begin
            s.a0 = dmaStartAdr[0*ADR_W +: ADR_W];
            s.a1 = dmaStartAdr[1*ADR_W +: ADR_W];
            s.a2 = dmaStartAdr[2*ADR_W +: ADR_W];
            startQ.push_back(s);
         end
         if (bufDone) begin
            doneQ.push_back(bufDoneIdx);
            relQ.push_back(cyc + longint'(relDelay));
         end
         hr = 1'b0;
         if (autoRel && relQ.size() > 0 && relQ[0] <= cyc) begin
            hr = 1'b1;
            void'(relQ.pop_front());
         end
         if (manReq != manSeen) begin
            hr      = 1'b1;
            manSeen = manReq;
         end
         HOST_RELEASE = hr;
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      assert (obs === exp) nPass++;
      else begin
         nFail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic doReset();
      RST = 1'b1; envClear = 1'b1; RUN = 1'b0; STOP = 1'b0;
      repeat (3) tick();
      RST = 1'b0; envClear = 1'b0;
      tick();
   endtask

   task automatic applyStimulus(input int ring, input int total, input int size, input int stride);
      cfgRing    = CNT_W'(ring);
      cfgTotal   = CNT_W'(total);
      cfgBufSize = ADR_W'(size);
      cfgStride  = ADR_W'(stride);
      cfgBase    = ADR_W'($urandom_range(0, 1 << 20));
      RUN = 1'b1;
      tick();
      RUN = 1'b0;
   endtask

   task automatic pulseStop();
      STOP = 1'b1;
      tick();
      STOP = 1'b0;
   endtask

   task automatic manualRelease();
      manReq++;
      repeat (3) tick();
   endtask

   task automatic waitStarts(input string tag, input int n, input int budget);
      int b = budget;
      while (startCnt[0] < n && b > 0) begin
         tick();
         b--;
      end
      checkOutput(tag, 64'(startCnt[0]), 64'(n));
   endtask

   task automatic waitIdle(input string tag, input int budget);
      int b = budget;
      while (busy !== 1'b0 && b > 0) begin
         tick();
         b--;
      end
      checkOutput(tag, 64'(busy), 64'd0);
      repeat (30) tick();
   endtask

   // Reference: buffer k of channel c lives at base + c*stride + (k mod ring)*size.
   task automatic checkAddrs(input string tag, input int n, input int ring);
      logic [ADR_W-1:0] e0;
      checkOutput({tag, "_nstarts"}, 64'(startQ.size()), 64'(n));
      for (int c = 0; c < NCH; c++)
         checkOutput($sformatf("%s_startcnt_ch%0d", tag, c), 64'(startCnt[c]), 64'(n));
      for (int k = 0; k < startQ.size() && k < n; k++) begin
         e0 = ADR_W'(longint'(cfgBase) + longint'(k % ring) * longint'(cfgBufSize));
         checkOutput($sformatf("%s_adr0_%0d", tag, k), 64'(startQ[k].a0), 64'(e0));
         checkOutput($sformatf("%s_adr1_%0d", tag, k), 64'(startQ[k].a1), 64'(ADR_W'(e0 + cfgStride)));
         checkOutput($sformatf("%s_adr2_%0d", tag, k), 64'(startQ[k].a2),
                     64'(ADR_W'(e0 + cfgStride + cfgStride)));
      end
   endtask

   task automatic checkDones(input string tag, input int n, input int ring);
      checkOutput({tag, "_ndone"}, 64'(doneQ.size()), 64'(n));
      for (int k = 0; k < doneQ.size() && k < n; k++)
         checkOutput($sformatf("%s_doneidx_%0d", tag, k), 64'(doneQ[k]), 64'(k % ring));
   endtask

   initial begin
      for (int c = 0; c < NCH; c++) begin
         preload[c] = CNT_W'($urandom_range(0, 1000));
         lat[c]     = 100;
      end

      // Reset state
      doReset();
      $display("[TB] reset checks");
      checkOutput("rst_start", 64'(dmaStart), 64'd0);
      checkOutput("rst_adr", 64'(dmaStartAdr[63:0]), 64'd0);
      checkOutput("rst_bufsize", 64'(dmaBufSize), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_bufdone", 64'(bufDone), 64'd0);
      checkOutput("rst_alldone", 64'(allDone), 64'd0);
      checkOutput("rst_errrel", 64'(errRelease), 64'd0);
      checkOutput("rst_errto", 64'(errTimeout), 64'd0);

      // Bring-up: 8 buffers over a 4-deep ring, host releases 20 cycles after each BUF_DONE
      $display("[TB] bring-up");
      autoRel = 1'b1; relDelay = 20;
      applyStimulus(4, 8, 972, 4096);
      checkOutput("bu_busy_after_run", 64'(busy), 64'd1);
      checkOutput("bu_bufsize", 64'(dmaBufSize), 64'd972);
      waitIdle("bu_idle", 5000);
      checkAddrs("bu", 8, 4);
      checkDones("bu", 8, 4);
      checkOutput("bu_alldone", 64'(allDone), 64'd1);
      checkOutput("bu_errrel", 64'(errRelease), 64'd0);

      // Ring backpressure: no releases, continuous mode
      $display("[TB] ring backpressure");
      for (int c = 0; c < NCH; c++) begin
         preload[c] = CNT_W'($urandom_range(0, 60000));
         lat[c]     = $urandom_range(20, 40);
      end
      doReset();
      autoRel = 1'b0;
      applyStimulus(4, 0, $urandom_range(1, 5000), $urandom_range(4096, 65536));
      waitStarts("bp_four", 4, 1000);
      repeat (300) tick();
      checkOutput("bp_stall_starts", 64'(startCnt[0]), 64'd4);
      checkOutput("bp_stall_busy", 64'(busy), 64'd1);
      manualRelease();
      waitStarts("bp_five", 5, 200);
      repeat (300) tick();
      checkOutput("bp_only_five", 64'(startCnt[0]), 64'd5);
      checkAddrs("bp", 5, 4);
      pulseStop();
      waitIdle("bp_stop_idle", 500);
      checkOutput("bp_alldone", 64'(allDone), 64'd0);

      // Error path: release at zero occupancy, then STOP with a buffer in flight
      $display("[TB] release error and stop");
      for (int c = 0; c < NCH; c++) lat[c] = 50;
      doReset();
      applyStimulus(1, 0, 100, 8192);
      waitStarts("er_first", 1, 200);
      repeat (150) tick();
      checkOutput("er_one_start", 64'(startCnt[0]), 64'd1);
      manualRelease();
      waitStarts("er_second", 2, 100);
      checkOutput("er_no_err_yet", 64'(errRelease), 64'd0);
      manualRelease();
      checkOutput("er_errrel_set", 64'(errRelease), 64'd1);
      repeat (200) tick();
      checkOutput("er_released_unchanged", 64'(startCnt[0]), 64'd2);
      manualRelease();
      waitStarts("er_third", 3, 100);
      pulseStop();
      repeat (3) tick();
      checkOutput("er_flush_busy", 64'(busy), 64'd1);
      waitIdle("er_stop_idle", 500);
      checkOutput("er_no_new_start", 64'(startCnt[0]), 64'd3);
      checkOutput("er_errrel_sticky", 64'(errRelease), 64'd1);
      checkAddrs("er", 3, 1);

      // Skewed channels: channel 2 lags by 300 cycles
      $display("[TB] skewed channels");
      lat[0] = 50; lat[1] = 50; lat[2] = 350;
      doReset();
      autoRel = 1'b1; relDelay = 5;
      applyStimulus(4, 2, 256, 1 << 16);
      waitStarts("sk_first", 1, 100);
      repeat (200) tick();
      checkOutput("sk_no_early_done", 64'(doneQ.size()), 64'd0);
      waitIdle("sk_idle", 3000);
      checkDones("sk", 2, 4);
      checkAddrs("sk", 2, 4);
      checkOutput("sk_alldone", 64'(allDone), 64'd1);

      // DONE_CNT rollover across 2^CNT_W
      $display("[TB] counter wrap");
      for (int c = 0; c < NCH; c++) begin
         preload[c] = CNT_W'($urandom_range(65530, 65535));
         lat[c]     = $urandom_range(20, 60);
      end
      preload[0] = 16'd65534;
      doReset();
      autoRel = 1'b1; relDelay = $urandom_range(1, 30);
      applyStimulus(2, 4, $urandom_range(1, 3000), $urandom_range(1, 100000));
      waitIdle("wr_idle", 3000);
      checkDones("wr", 4, 2);
      checkAddrs("wr", 4, 2);
      checkOutput("wr_alldone", 64'(allDone), 64'd1);
      checkOutput("wr_errrel", 64'(errRelease), 64'd0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
